regbank_debug_dumper: RTL and testbench

//  Debug-side sequencer for the register bank. It walks every register

---
 rtl/regbank_debug_dumper_pkg.sv | 16 +
 rtl/regbank_debug_dumper.sv | 118 +++++++++++
 tb/tb_regbank_debug_dumper.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/regbank_debug_dumper_pkg.sv
// Shared definitions for the register-bank debug dumper: FSM encoding and default geometry.
package regbank_debug_dumper_pkg;

  localparam int unsigned DEF_ADDR_BITS  = 5;
  localparam int unsigned DEF_WORD_WIDE  = 32;
  localparam int unsigned DEF_BYTE_BITS  = 8;
  localparam int unsigned BYTES_PER_WORD = DEF_WORD_WIDE / DEF_BYTE_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } dumpState_e;

endpackage : regbank_debug_dumper_pkg

// File: rtl/regbank_debug_dumper.sv
// Walks every register through the bank debug read port and streams each word
// out MSB byte first over a valid/ready handshake toward the debug UART TX.
module regbank_debug_dumper
  import regbank_debug_dumper_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
  parameter int unsigned WORD_WIDE = DEF_WORD_WIDE,
  parameter int unsigned BYTE_BITS = DEF_BYTE_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic [ADDR_BITS-1:0] dbg_addr,
  input  logic [WORD_WIDE-1:0] dbg_data,
  output logic [BYTE_BITS-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned WORD_BYTES = WORD_WIDE / BYTE_BITS;
  localparam int unsigned CNT_BITS   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CNT_BITS-1:0]  LAST_BYTE = CNT_BITS'(WORD_BYTES - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  dumpState_e           state;
  dumpState_e           nextState;
  logic [ADDR_BITS-1:0] addrQ;
  logic [ADDR_BITS-1:0] nextAddr;
  logic [WORD_WIDE-1:0] shiftReg;
  logic [WORD_WIDE-1:0] nextShift;
  logic [CNT_BITS-1:0]  byteCount;
  logic [CNT_BITS-1:0]  nextCount;
  logic                 validQ;
  logic                 busyQ;
  logic                 doneQ;
  logic                 nextValid;
  logic                 nextBusy;
  logic                 nextDone;
  logic                 xferC;

  // State, datapath and registered outputs; reset aborts any dump in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addrQ     <= '0;
      shiftReg  <= '0;
      byteCount <= '0;
      validQ    <= 1'b0;
      busyQ     <= 1'b0;
      doneQ     <= 1'b0;
    end else begin
      state     <= nextState;
      addrQ     <= nextAddr;
      shiftReg  <= nextShift;
      byteCount <= nextCount;
      validQ    <= nextValid;
      busyQ     <= nextBusy;
      doneQ     <= nextDone;
    end
  end

  // Next-state logic; outputs are derived from the next state so they line up with it.
  always_comb begin
    nextState = state;
    nextAddr  = addrQ;
    nextShift = shiftReg;
    nextCount = byteCount;
    xferC     = validQ && tx_ready;

    unique case (state)
      IDLE: begin
        if (start) begin
          nextAddr  = '0;
          nextState = LATCH;
        end
      end
      LATCH: begin
        nextShift = dbg_data;
        nextCount = '0;
        nextState = SEND;
      end
      SEND: begin
        if (xferC) begin
          nextShift = shiftReg << BYTE_BITS;
          nextCount = byteCount + CNT_BITS'(1);
          if (byteCount == LAST_BYTE) begin
            // Terminal check precedes the increment so the address never wraps.
            if (addrQ == LAST_ADDR) begin
              nextState = DONE;
            end else begin
              nextAddr  = addrQ + ADDR_BITS'(1);
              nextState = LATCH;
            end
          end
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase

    nextValid = (nextState == SEND);
    nextBusy  = (nextState == LATCH) || (nextState == SEND);
    nextDone  = (nextState == DONE);
  end

  assign dbg_addr = addrQ;
  assign tx_data  = shiftReg[WORD_WIDE-1 -: BYTE_BITS];
  assign tx_valid = validQ;
  assign busy     = busyQ;
  assign done     = doneQ;

endmodule : regbank_debug_dumper

// File: tb/tb_regbank_debug_dumper.sv
// Directed bench for the register-bank debug dumper with a small bank model.
module tb_regbank_debug_dumper;

  logic        clock;
  logic        reset;
  logic        start;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  logic [31:0] regs [32];
  logic [7:0]  bytesQ [$];

  int checkCount = 0;
  int errorCount = 0;
  int doneCount;
  int doneCycle;
  int firstValid;
  bit aborted;

  regbank_debug_dumper dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  // Bank debug read port is combinational.
  assign dbg_data = regs[dbg_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] expByte(input int idx);
    logic [31:0] w;
    w = regs[idx / 4];
    return w[8*(3 - idx % 4) +: 8];
  endfunction

  task automatic preload();
    for (int i = 0; i < 32; i++) regs[i] = 32'hA0B0C000 + 32'(i);
  endtask

  // One dump: cycle 0 is the cycle start is driven (sampled at edge 1).
  // readyMode 0: tx_ready=1; 1: one cycle on, two off. abortAfter>0 resets after that many bytes.
  task automatic runDump(input int readyMode, input bit extraStarts, input int abortAfter);
    int  c;
    bit  prevStall;
    logic [7:0] prevData;
    bit  finished;
    bytesQ.delete();
    doneCount  = 0;
    doneCycle  = -1;
    firstValid = -1;
    aborted    = 1'b0;
    prevStall  = 1'b0;
    prevData   = '0;
    finished   = 1'b0;
    c          = 0;
    while (!finished && c < 2000) begin
      start    = (c == 0) || (extraStarts && (c == 5 || c == 50 || c == 161));
      tx_ready = (readyMode == 0) ? 1'b1 : (c % 3 == 0);
      if (tx_valid && firstValid < 0) firstValid = c;
      if (prevStall) begin
        checkEq("stall_valid", 32'(tx_valid), 32'd1);
        checkEq("stall_data", 32'(tx_data), 32'(prevData));
      end
      prevStall = tx_valid && !tx_ready;
      prevData  = tx_data;
      if (done) begin
        doneCount++;
        doneCycle = c;
        checkEq("busy_at_done", 32'(busy), 32'd0);
      end
      if (tx_valid && tx_ready) bytesQ.push_back(tx_data);
      @(posedge clock);
      #1;
      c++;
      if (abortAfter > 0 && bytesQ.size() == abortAfter) begin
        start = 1'b0;
        reset = 1'b0;
        #1;
        checkEq("abort_valid", 32'(tx_valid), 32'd0);
        checkEq("abort_busy", 32'(busy), 32'd0);
        checkEq("abort_done", 32'(done), 32'd0);
        repeat (3) begin
          @(posedge clock);
          #1;
          if (done) doneCount++;
        end
        reset   = 1'b1;
        aborted = 1'b1;
        finished = 1'b1;
      end
      if (doneCount > 0 && c >= doneCycle + 5) finished = 1'b1;
    end
    start = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    tx_ready = 1'b0;
    preload();
    repeat (3) @(posedge clock);
    #1;
    checkEq("reset_outputs", {17'd0, dbg_addr, tx_data, tx_valid, busy}, 32'd0);
    checkEq("reset_done", 32'(done), 32'd0);
    reset = 1'b1;

    // Idle with no start: everything stays 0.
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      checkEq("idle_outputs", {16'd0, done, dbg_addr, tx_data, tx_valid, busy}, 32'd0);
    end

    // Full dump, transmitter always ready.
    runDump(0, 1'b0, 0);
    checkEq("t2_count", 32'(bytesQ.size()), 32'd128);
    checkEq("t2_first_valid", 32'(firstValid), 32'd2);
    checkEq("t2_done_cycle", 32'(doneCycle), 32'd161);
    checkEq("t2_done_count", 32'(doneCount), 32'd1);
    if (bytesQ.size() == 128) begin
      checkEq("t2_b0", 32'(bytesQ[0]), 32'hA0);
      checkEq("t2_b1", 32'(bytesQ[1]), 32'hB0);
      checkEq("t2_b2", 32'(bytesQ[2]), 32'hC0);
      checkEq("t2_b3", 32'(bytesQ[3]), 32'h00);
      checkEq("t2_b7", 32'(bytesQ[7]), 32'h01);
      checkEq("t2_b127", 32'(bytesQ[127]), 32'h1F);
      for (int i = 0; i < 128; i++) checkEq("t2_byte", 32'(bytesQ[i]), 32'(expByte(i)));
    end
    checkEq("t2_idle_busy", 32'(busy), 32'd0);
    checkEq("t2_idle_addr", 32'(dbg_addr), 32'd31);

    // Back-pressure: ready one cycle on, two off.
    runDump(1, 1'b0, 0);
    checkEq("t3_count", 32'(bytesQ.size()), 32'd128);
    checkEq("t3_done_count", 32'(doneCount), 32'd1);
    if (bytesQ.size() == 128)
      for (int i = 0; i < 128; i++) checkEq("t3_byte", 32'(bytesQ[i]), 32'(expByte(i)));

    // Extra starts during the dump and in DONE are ignored.
    runDump(0, 1'b1, 0);
    checkEq("t4_count", 32'(bytesQ.size()), 32'd128);
    checkEq("t4_done_count", 32'(doneCount), 32'd1);
    checkEq("t4_done_cycle", 32'(doneCycle), 32'd161);
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    checkEq("t4_no_restart", {30'd0, busy, tx_valid}, 32'd0);

    // Reset mid-dump after the 37th byte, then a fresh dump.
    runDump(0, 1'b0, 37);
    checkEq("t5_aborted", 32'(aborted), 32'd1);
    checkEq("t5_partial_count", 32'(bytesQ.size()), 32'd37);
    checkEq("t5_no_done", 32'(doneCount), 32'd0);
    checkEq("t5_addr_reset", 32'(dbg_addr), 32'd0);
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    checkEq("t5_stays_idle", {30'd0, busy, tx_valid}, 32'd0);
    runDump(0, 1'b0, 0);
    checkEq("t5_fresh_count", 32'(bytesQ.size()), 32'd128);
    if (bytesQ.size() == 128) begin
      checkEq("t5_fresh_b0", 32'(bytesQ[0]), 32'hA0);
      checkEq("t5_fresh_b3", 32'(bytesQ[3]), 32'h00);
    end

    // Boundary registers: last word all ones, first word zero.
    regs[31] = 32'hFFFFFFFF;
    regs[0]  = 32'h0;
    runDump(0, 1'b0, 0);
    checkEq("t6_count", 32'(bytesQ.size()), 32'd128);
    if (bytesQ.size() == 128) begin
      checkEq("t6_first_word", {bytesQ[0], bytesQ[1], bytesQ[2], bytesQ[3]}, 32'h0);
      checkEq("t6_last_word", {bytesQ[124], bytesQ[125], bytesQ[126], bytesQ[127]}, 32'hFFFFFFFF);
    end
    checkEq("t6_done_count", 32'(doneCount), 32'd1);
    checkEq("t6_addr_no_wrap", 32'(dbg_addr), 32'd31);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule : tb_regbank_debug_dumper
